// File: rtl/arch_defs_pkg.sv
// Shared CPU architecture constants plus the MAR sequencer state and grant encodings.
// Pure declarations; no timing or flow control of its own.
package arch_defs_pkg;

   localparam int ADDR_WIDTH = 16;
   localparam int DATA_WIDTH = 8;

   localparam logic [ADDR_WIDTH-1:0] RESET_VECTOR_ADDR_LOW  = 16'hFFFE;
   localparam logic [ADDR_WIDTH-1:0] RESET_VECTOR_ADDR_HIGH = 16'hFFFF;

   typedef enum logic [3:0] {
      BOOT,
      RV_LO,
      RV_LO_WAIT,
      RV_HI,
      RV_HI_WAIT,
      VEC_DONE,
      IDLE,
      LD_PC,
      LD_SP,
      OPND_HI,
      OPND_LO,
      WAIT,
      ACK
   } mem_seq_state_t;

   typedef enum logic [1:0] {
      NONE,
      FETCH,
      STACK,
      OPND
   } mem_grant_t;

   // States whose successor is a memory wait state; the latency counter reloads here.
   function automatic logic is_wait_entry(input mem_seq_state_t s);
      return (s == RV_LO) || (s == RV_HI) || (s == LD_PC) || (s == LD_SP) || (s == OPND_LO);
   endfunction

endpackage

// File: rtl/latency_counter.sv
// Loadable 4-bit down-counter; done is high while the count sits at zero.
// Loads take effect on the next edge; counting stops at zero until the next load.
module latency_counter (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       load,
   input  logic [3:0] load_val,
   output logic       done
);

   logic [3:0] count;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= 4'd0;
      end else if (load) begin
         count <= load_val;
      end else if (count != 4'd0) begin
         count <= count - 4'd1;
      end
   end

   assign done = (count == 4'd0);

endmodule

// File: rtl/memory_access_sequencer.sv
// Boots the reset vector, then arbitrates MAR loads (stack > operand > fetch) paced by MEM_LATENCY.
// Moore outputs only; requesters hold their request until acked, one grant per IDLE visit.
module memory_access_sequencer
   import arch_defs_pkg::*;
#(
   parameter int MEM_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  fetch_req,
   output logic                  fetch_ack,
   input  logic                  stack_req,
   output logic                  stack_ack,
   input  logic                  opnd_req,
   output logic                  opnd_ack,
   output logic                  opnd_byte_hi,
   input  logic [DATA_WIDTH-1:0] mem_data_in,
   output logic                  load_pc,
   output logic                  load_sp,
   output logic                  load_addr_high,
   output logic                  load_addr_low,
   output logic                  load_reset_vec_addr_low,
   output logic                  load_reset_vec_addr_high,
   output logic                  mem_rd,
   output logic [ADDR_WIDTH-1:0] vector_out,
   output logic                  vector_valid,
   output logic                  busy
);

   if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_bad_latency
      $error("memory_access_sequencer: MEM_LATENCY must be in 1..15");
   end

   localparam logic [3:0] RELOAD = 4'(MEM_LATENCY - 1);

   mem_seq_state_t        state_q, state_d;
   mem_grant_t            grant_q, grant_d;
   logic                  rst_seen;
   logic                  lat_done;
   logic [ADDR_WIDTH-1:0] vector_q;

   latency_counter u_latency_counter (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (is_wait_entry(state_q)),
      .load_val (RELOAD),
      .done     (lat_done)
   );

   // BOOT spans the first full cycle after reset release, hence the extra flag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= BOOT;
         rst_seen <= 1'b0;
      end else begin
         state_q  <= state_d;
         rst_seen <= 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      case (state_q)
         BOOT:       if (rst_seen) state_d = RV_LO;
         RV_LO:      state_d = RV_LO_WAIT;
         RV_LO_WAIT: if (lat_done) state_d = RV_HI;
         RV_HI:      state_d = RV_HI_WAIT;
         RV_HI_WAIT: if (lat_done) state_d = VEC_DONE;
         VEC_DONE:   state_d = IDLE;
         IDLE: begin
            if (stack_req) begin
               state_d = LD_SP;
               grant_d = STACK;
            end else if (opnd_req) begin
               state_d = OPND_HI;
               grant_d = OPND;
            end else if (fetch_req) begin
               state_d = LD_PC;
               grant_d = FETCH;
            end
         end
         LD_PC:      state_d = WAIT;
         LD_SP:      state_d = WAIT;
         OPND_HI:    state_d = OPND_LO;
         OPND_LO:    state_d = WAIT;
         WAIT:       if (lat_done) state_d = ACK;
         ACK:        state_d = IDLE;
         default:    state_d = BOOT;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         grant_q  <= NONE;
         vector_q <= '0;
      end else begin
         grant_q <= grant_d;
         if (state_q == RV_LO_WAIT && lat_done) begin
            vector_q[DATA_WIDTH-1:0] <= mem_data_in;
         end
         if (state_q == RV_HI_WAIT && lat_done) begin
            vector_q[ADDR_WIDTH-1:DATA_WIDTH] <= mem_data_in;
         end
      end
   end

   always_comb begin
      load_pc                  = 1'b0;
      load_sp                  = 1'b0;
      load_addr_high           = 1'b0;
      load_addr_low            = 1'b0;
      load_reset_vec_addr_low  = 1'b0;
      load_reset_vec_addr_high = 1'b0;
      opnd_byte_hi             = 1'b0;
      mem_rd                   = 1'b0;
      vector_valid             = 1'b0;
      fetch_ack                = 1'b0;
      stack_ack                = 1'b0;
      opnd_ack                 = 1'b0;
      busy                     = (state_q != IDLE);
      case (state_q)
         RV_LO:      load_reset_vec_addr_low = 1'b1;
         RV_HI:      load_reset_vec_addr_high = 1'b1;
         RV_LO_WAIT: mem_rd = 1'b1;
         RV_HI_WAIT: mem_rd = 1'b1;
         WAIT:       mem_rd = 1'b1;
         VEC_DONE:   vector_valid = 1'b1;
         LD_PC:      load_pc = 1'b1;
         LD_SP:      load_sp = 1'b1;
         OPND_HI: begin
            load_addr_high = 1'b1;
            opnd_byte_hi   = 1'b1;
         end
         OPND_LO:    load_addr_low = 1'b1;
         ACK: begin
            fetch_ack = (grant_q == FETCH);
            stack_ack = (grant_q == STACK);
            opnd_ack  = (grant_q == OPND);
         end
         default: ;
      endcase
   end

   assign vector_out = vector_q;

endmodule

// File: tb/tb_memory_access_sequencer.sv
// Bench for memory_access_sequencer: two instances (latency 1 and 3) with behavioural reset-vector memories.
module tb_memory_access_sequencer;
   import arch_defs_pkg::*;

   localparam int L1 = 1;
   localparam int L3 = 3;

   typedef struct {
      logic [2:0] who;
      int         cyc;
   } sb_t;

   typedef struct {
      string      name;
      logic [2:0] req;
      logic [5:0] strb;
      logic       hi;
   } vec_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;

   logic fetch_req1 = 1'b0, stack_req1 = 1'b0, opnd_req1 = 1'b0;
   logic fetch_req3 = 1'b0, stack_req3 = 1'b0, opnd_req3 = 1'b0;
   logic fetch_ack1, stack_ack1, opnd_ack1, opnd_hi1, mem_rd1, vv1, busy1;
   logic fetch_ack3, stack_ack3, opnd_ack3, opnd_hi3, mem_rd3, vv3, busy3;
   logic lpc1, lsp1, lah1, lal1, lrl1, lrh1;
   logic lpc3, lsp3, lah3, lal3, lrl3, lrh3;
   logic [15:0] vec1, vec3;
   logic [7:0]  mem_data1, mem_data3;
   logic [15:0] mar1, mar3;
   logic [3:0]  age1, age3;
   logic [5:0]  strb1, strb3;

   int   tests = 0;
   int   failed = 0;
   int   cyc = 0;
   int   viol = 0;
   sb_t  q[2][$];
   logic [2:0] drop[2];
   int   vv_cnt[2];
   int   vv_cyc[2];
   vec_t vt[7];

   always #5 clk = ~clk;

   memory_access_sequencer #(.MEM_LATENCY(L1)) dut1 (
      .clk(clk), .reset_n(reset_n),
      .fetch_req(fetch_req1), .fetch_ack(fetch_ack1),
      .stack_req(stack_req1), .stack_ack(stack_ack1),
      .opnd_req(opnd_req1), .opnd_ack(opnd_ack1),
      .opnd_byte_hi(opnd_hi1), .mem_data_in(mem_data1),
      .load_pc(lpc1), .load_sp(lsp1), .load_addr_high(lah1), .load_addr_low(lal1),
      .load_reset_vec_addr_low(lrl1), .load_reset_vec_addr_high(lrh1),
      .mem_rd(mem_rd1), .vector_out(vec1), .vector_valid(vv1), .busy(busy1)
   );

   memory_access_sequencer #(.MEM_LATENCY(L3)) dut3 (
      .clk(clk), .reset_n(reset_n),
      .fetch_req(fetch_req3), .fetch_ack(fetch_ack3),
      .stack_req(stack_req3), .stack_ack(stack_ack3),
      .opnd_req(opnd_req3), .opnd_ack(opnd_ack3),
      .opnd_byte_hi(opnd_hi3), .mem_data_in(mem_data3),
      .load_pc(lpc3), .load_sp(lsp3), .load_addr_high(lah3), .load_addr_low(lal3),
      .load_reset_vec_addr_low(lrl3), .load_reset_vec_addr_high(lrh3),
      .mem_rd(mem_rd3), .vector_out(vec3), .vector_valid(vv3), .busy(busy3)
   );

   assign strb1 = {lpc1, lsp1, lah1, lal1, lrl1, lrh1};
   assign strb3 = {lpc3, lsp3, lah3, lal3, lrl3, lrh3};

   // Memory returns junk until the configured latency has elapsed since the MAR load.
   function automatic logic [7:0] mem_read(input logic [15:0] mar, input logic [3:0] age, input int lat);
      if (int'(age) + 1 < lat) return 8'hA5;
      if (mar == RESET_VECTOR_ADDR_LOW) return 8'h00;
      if (mar == RESET_VECTOR_ADDR_HIGH) return 8'h80;
      return 8'hEE;
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mar1 <= 16'h0; age1 <= 4'hF; mar3 <= 16'h0; age3 <= 4'hF;
      end else begin
         if (lrl1) begin mar1 <= RESET_VECTOR_ADDR_LOW; age1 <= 4'h0; end
         else if (lrh1) begin mar1 <= RESET_VECTOR_ADDR_HIGH; age1 <= 4'h0; end
         else if (age1 != 4'hF) age1 <= age1 + 4'h1;
         if (lrl3) begin mar3 <= RESET_VECTOR_ADDR_LOW; age3 <= 4'h0; end
         else if (lrh3) begin mar3 <= RESET_VECTOR_ADDR_HIGH; age3 <= 4'h0; end
         else if (age3 != 4'hF) age3 <= age3 + 4'h1;
      end
   end

   assign mem_data1 = mem_read(mar1, age1, L1);
   assign mem_data3 = mem_read(mar3, age3, L3);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic monitor(input int d, input logic [2:0] ackv, input logic [5:0] strb, input logic vv);
      sb_t e;
      if (ackv != 3'b000) begin
         if (q[d].size() == 0) begin
            check($sformatf("unexpected_ack_dut%0d", d), 32'(ackv), 32'h0);
         end else begin
            e = q[d].pop_front();
            check($sformatf("ack_who_dut%0d", d), 32'(ackv), 32'(e.who));
            check($sformatf("ack_cycle_dut%0d", d), cyc, e.cyc);
         end
         drop[d] = ackv;
      end
      if ($countones(strb) > 1 || $countones(ackv) > 1) viol++;
      if (vv) begin
         if (vv_cnt[d] == 0) vv_cyc[d] = cyc;
         vv_cnt[d]++;
      end
   endtask

   // One clock: requesters drop acked requests just after the edge, outputs are sampled at negedge.
   task automatic tick();
      @(posedge clk);
      cyc++;
      #1;
      if (drop[0][2]) stack_req1 = 1'b0;
      if (drop[0][1]) opnd_req1 = 1'b0;
      if (drop[0][0]) fetch_req1 = 1'b0;
      if (drop[1][2]) stack_req3 = 1'b0;
      if (drop[1][1]) opnd_req3 = 1'b0;
      if (drop[1][0]) fetch_req3 = 1'b0;
      drop[0] = 3'b000;
      drop[1] = 3'b000;
      @(negedge clk);
      monitor(0, {stack_ack1, opnd_ack1, fetch_ack1}, strb1, vv1);
      monitor(1, {stack_ack3, opnd_ack3, fetch_ack3}, strb3, vv3);
   endtask

   // Expected ack cycles: one grant per IDLE visit in priority order, next grant sampled the edge after ACK.
   task automatic push_expected(input int d, input int e_edge, input logic [2:0] req, input int lat);
      int t;
      int off;
      sb_t e;
      t = e_edge;
      for (int b = 2; b >= 0; b--) begin
         if (req[b]) begin
            off = (b == 1) ? 3 + lat : 2 + lat;
            e.who = 3'(1 << b);
            e.cyc = t + off - 1;
            q[d].push_back(e);
            t = t + off + 1;
         end
      end
   endtask

   task automatic wait_idle(input int d);
      int n;
      n = 0;
      while (((d == 0) ? busy1 : busy3) && n < 100) begin
         tick();
         n++;
      end
      check($sformatf("idle_reached_dut%0d", d), 32'((d == 0) ? busy1 : busy3), 32'h0);
   endtask

   task automatic wait_drain(input int d);
      int n;
      n = 0;
      while (q[d].size() > 0 && n < 200) begin
         tick();
         n++;
      end
      check($sformatf("acks_outstanding_dut%0d", d), q[d].size(), 0);
      q[d].delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_outs_dut1"}, 32'({strb1, fetch_ack1, stack_ack1, opnd_ack1, opnd_hi1, mem_rd1, vv1}), 32'h0);
      check({tag, "_busy_dut1"}, 32'(busy1), 32'h1);
      check({tag, "_vector_dut1"}, 32'(vec1), 32'h0);
      check({tag, "_outs_dut3"}, 32'({strb3, fetch_ack3, stack_ack3, opnd_ack3, opnd_hi3, mem_rd3, vv3}), 32'h0);
      check({tag, "_busy_dut3"}, 32'(busy3), 32'h1);
      check({tag, "_vector_dut3"}, 32'(vec3), 32'h0);
   endtask

   // Release reset at a negedge; the next posedge is the first edge with reset_n high.
   task automatic boot(input string tag, input logic fetch_during_boot);
      int r;
      sb_t e;
      vv_cnt[0] = 0; vv_cnt[1] = 0;
      vv_cyc[0] = -1; vv_cyc[1] = -1;
      r = cyc + 1;
      if (fetch_during_boot) begin
         fetch_req1 = 1'b1;
         e.who = 3'b001;
         e.cyc = r + 2 * L1 + 3 + 4;
         q[0].push_back(e);
      end
      reset_n = 1'b1;
      repeat (30) tick();
      check({tag, "_vv_cycle_dut1"}, vv_cyc[0], r + 2 * L1 + 3);
      check({tag, "_vv_pulses_dut1"}, vv_cnt[0], 1);
      check({tag, "_vector_dut1"}, 32'(vec1), 32'h8000);
      check({tag, "_vv_cycle_dut3"}, vv_cyc[1], r + 2 * L3 + 3);
      check({tag, "_vv_pulses_dut3"}, vv_cnt[1], 1);
      check({tag, "_vector_dut3"}, 32'(vec3), 32'h8000);
      wait_drain(0);
   endtask

   initial begin
      int e_edge;
      vt[0] = '{"fetch",       3'b001, 6'b100000, 1'b0};
      vt[1] = '{"stack",       3'b100, 6'b010000, 1'b0};
      vt[2] = '{"opnd",        3'b010, 6'b001000, 1'b1};
      vt[3] = '{"stack_fetch", 3'b101, 6'b010000, 1'b0};
      vt[4] = '{"opnd_fetch",  3'b011, 6'b001000, 1'b1};
      vt[5] = '{"all_three",   3'b111, 6'b010000, 1'b0};
      vt[6] = '{"stack_opnd",  3'b110, 6'b010000, 1'b0};
      drop[0] = 3'b000;
      drop[1] = 3'b000;

      reset_n = 1'b0;
      repeat (3) tick();
      check_reset_outputs("reset");
      boot("boot", 1'b1);

      foreach (vt[i]) begin
         wait_idle(0);
         e_edge = cyc + 1;
         {stack_req1, opnd_req1, fetch_req1} = vt[i].req;
         push_expected(0, e_edge, vt[i].req, L1);
         tick();
         check({vt[i].name, "_first_strobe"}, 32'(strb1), 32'(vt[i].strb));
         check({vt[i].name, "_byte_hi"}, 32'(opnd_hi1), 32'(vt[i].hi));
         wait_drain(0);
      end

      // Fetch on the latency-3 instance.
      wait_idle(1);
      e_edge = cyc + 1;
      fetch_req3 = 1'b1;
      push_expected(1, e_edge, 3'b001, L3);
      tick();
      check("l3_fetch_strobe", 32'(strb3), 32'h20);
      tick();
      check("l3_fetch_mem_rd", 32'(mem_rd3), 32'h1);
      wait_drain(1);

      // Operand access, byte by byte.
      wait_idle(0);
      e_edge = cyc + 1;
      opnd_req1 = 1'b1;
      push_expected(0, e_edge, 3'b010, L1);
      tick();
      check("opnd_hi_strobe", 32'({strb1, opnd_hi1}), 32'({6'b001000, 1'b1}));
      tick();
      check("opnd_lo_strobe", 32'({strb1, opnd_hi1}), 32'({6'b000100, 1'b0}));
      tick();
      check("opnd_wait_mem_rd", 32'(mem_rd1), 32'h1);
      wait_drain(0);

      // Reset during the wait of a fetch: no ack, immediate reset outputs, clean reboot.
      wait_idle(0);
      fetch_req1 = 1'b1;
      tick();
      tick();
      check("midrst_in_wait", 32'(mem_rd1), 32'h1);
      #2;
      reset_n = 1'b0;
      fetch_req1 = 1'b0;
      #1;
      check_reset_outputs("midrst");
      q[0].delete();
      repeat (3) tick();
      boot("reboot", 1'b0);

      check("onehot_violations", viol, 0);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/memory_access_sequencer.md
# memory_access_sequencer

Sequences every load of the memory address register (MAR) and arbitrates MAR access between the three CPU-internal requesters: instruction fetch (PC), stack (SP) and operand address (two bytes from the data bus). After reset release it runs the reset-vector fetch on its own and delivers the 16-bit vector for the program counter. It sits between the control unit's request lines and the MAR load strobes, and paces each access by a fixed memory read latency.

## Interface

Parameters:

- `MEM_LATENCY`, default 1. Cycles from MAR capture to valid `mem_data_in`. Legal range 1..15.

Ports:

- `clk`  in  1  system clock. Single clock domain.
- `reset_n`  in  1  asynchronous, active-low reset.
- `fetch_req` / `fetch_ack`  in / out  1 / 1  PC-address access request and completion pulse.
- `stack_req` / `stack_ack`  in / out  1 / 1  SP-address access request and completion pulse.
- `opnd_req` / `opnd_ack`  in / out  1 / 1  operand-address access request and completion pulse.
- `opnd_byte_hi`  out  1  high while the operand requester must drive the high address byte on the bus.
- `mem_data_in`  in  `DATA_WIDTH`  memory read data; used only during the vector fetch.
- `load_pc`, `load_sp`, `load_addr_high`, `load_addr_low`, `load_reset_vec_addr_low`, `load_reset_vec_addr_high`  out  1 each  MAR load strobes. At most one is high in any cycle.
- `mem_rd`  out  1  high during access wait cycles.
- `vector_out`  out  `ADDR_WIDTH`  assembled reset vector.
- `vector_valid`  out  1  one-cycle pulse; PC loads `vector_out`.
- `busy`  out  1  high in every state except IDLE.

## Operation

- FSM states: BOOT, RV_LO, RV_LO_WAIT, RV_HI, RV_HI_WAIT, VEC_DONE, IDLE, LD_PC, LD_SP, OPND_HI, OPND_LO, WAIT, ACK.
- All outputs are Moore, decoded from registered state. No combinational path runs from a request input to any output.

Boot sequence:

- BOOT (1 cycle) → RV_LO: `load_reset_vec_addr_low` high → RV_LO_WAIT.
- RV_LO_WAIT lasts `MEM_LATENCY` cycles with `mem_rd` high. On the clock edge ending the last wait cycle, `vector_out[7:0]` ← `mem_data_in`.
- RV_HI, then RV_HI_WAIT, behave the same way and capture `vector_out[15:8]`.
- VEC_DONE: `vector_valid` high for 1 cycle → IDLE.
- Requests are ignored (never acked) before IDLE. A requester holds its request until it is acked.

Arbitration in IDLE:

- Fixed priority: stack > operand > fetch.
- Losing requests stay pending and are not lost.
- Stack grant: LD_SP (`load_sp`) → WAIT.
- Fetch grant: LD_PC (`load_pc`) → WAIT.
- Operand grant: OPND_HI (`load_addr_high`, `opnd_byte_hi`=1) → OPND_LO (`load_addr_low`, `opnd_byte_hi`=0) → WAIT.
- WAIT lasts `MEM_LATENCY` cycles with `mem_rd` high, then ACK.
- ACK asserts the granted requester's ack for 1 cycle → IDLE.

Requester rules:

- Each requester deasserts its request in the cycle after it sees its ack.
- A request still high in IDLE starts a new access. Back-to-back accesses are legal.

Counters and widths:

- The wait counter is 4 bits. It loads `MEM_LATENCY`-1 on entry to any wait state and counts down to 0.
- `MEM_LATENCY`=0 is illegal and is caught by an elaboration assertion.

## Timing

- Reset values: all strobes, acks, `mem_rd`, `vector_valid` = 0; `vector_out` = 0; `busy` = 1; state = BOOT.
- Asserting `reset_n` mid-access drops all outputs within the same cycle (asynchronous). The boot sequence then reruns after release. No partial ack is ever produced.
- Boot: `vector_valid` rises 2·`MEM_LATENCY`+4 cycles after the first rising edge with `reset_n` high.
- Request sampled at edge E in IDLE:
  - Fetch or stack: strobe in cycle E+1, ack in cycle E+2+`MEM_LATENCY`.
  - Operand: `load_addr_high` in E+1, `load_addr_low` in E+2, ack in E+3+`MEM_LATENCY`.
- Simultaneous requests: exactly one grant per IDLE visit. The pending lower-priority request is granted from the next IDLE, the cycle after ACK.
- Requests arriving during a busy state are served from the next IDLE.

## Structure

- `arch_defs_pkg` holds:
  - existing `ADDR_WIDTH`, `DATA_WIDTH`, `RESET_VECTOR_ADDR_LOW/HIGH`;
  - new `mem_seq_state_t` enum;
  - new `mem_grant_t` enum (NONE, FETCH, STACK, OPND).
- One sub-module, `latency_counter`: loadable 4-bit down-counter with a `done` flag, reused by all wait states.

## Test plan

- Memory holds 0x00 at `RESET_VECTOR_ADDR_LOW` and 0x80 at `RESET_VECTOR_ADDR_HIGH`; release reset with `MEM_LATENCY`=1 → `vector_valid` pulses once, `vector_out`=0x8000, 6 cycles after release.
- In IDLE, `fetch_req`=1 → `load_pc` in cycle +1, `mem_rd` in cycle +2, `fetch_ack` in cycle +3; repeat with `MEM_LATENCY`=3 → ack in cycle +5.
- `stack_req`, `opnd_req` and `fetch_req` all asserted in the same cycle → acks in order stack, operand, fetch. Never two strobes in one cycle, never two acks in one cycle.
- Operand access → `opnd_byte_hi`=1 exactly in the `load_addr_high` cycle; `load_addr_low` in the next cycle; `opnd_ack` after the latency window.
- `reset_n` pulled low during the WAIT of a fetch → no `fetch_ack`, outputs at their reset values immediately, the boot sequence repeats, and the vector is re-fetched correctly.
- `fetch_req` asserted during boot → no ack until after `vector_valid`; first ack exactly 3 cycles after IDLE is entered.
